mac_seq_ctrl: RTL
=================

// Module: mac_seq_ctrl
// PURPOSE
//  Sequencer for the 18-bit multiply-accumulate datapath (mac). On start it clears the
//  accumulator and streams len operand pairs from an external operand memory. It then
//  waits out the MAC latency, captures the accumulated sum and pulses done.
//  Sits between the control/test logic (start/len/result) and the mac instance plus its operand RAM.
// PARAMETERS
//  AW       4   operand-memory address width; max terms = 2**AW
//  ACC_W   18   accumulator/result width (matches mac out)
//  MAC_LAT  1   cycles from a mac_en edge until mac_out reflects that term (>=1)
// PORTS
//  clk      in   1      single clock, rising edge
//  rst      in   1      asynchronous, active-high reset
//  start    in   1      request a dot product; sampled only in IDLE
//  abort    in   1      synchronous abort; returns to IDLE, no done
//  len      in   AW+1   term count, sampled with start; 0 allowed; >2**AW clamps to 2**AW
//  rd_en    out  1      operand-memory read strobe (memory read latency fixed at 1 cycle)
//  rd_addr  out  AW     operand-memory address
//  mac_clr  out  1      accumulator clear to mac, 1-cycle pulse
//  mac_en   out  1      accumulate enable to mac = rd_en delayed 1 cycle
//  mac_out  in   ACC_W  accumulator value from mac
//  busy     out  1      high in CLEAR/ISSUE/DRAIN
//  done     out  1      1-cycle pulse; result valid in the same cycle
//  result   out  ACC_W  captured sum; holds until the next done
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; rd_en, rd_addr, mac_clr, mac_en, busy, done, result = 0.
//  All outputs are registered. Cycle 0 = the cycle in which start is sampled high in IDLE.
//  FSM IDLE->CLEAR->ISSUE->DRAIN->DONE->IDLE:
//   IDLE : start=1 -> latch clamp(len). len==0 -> DONE (done at cycle 1, result=0,
//          no rd_en, no mac_clr). Otherwise -> CLEAR.
//   CLEAR: mac_clr=1 for 1 cycle; rd_en=1, rd_addr=0 (cycle 1). -> ISSUE, or -> DRAIN if len==1.
//   ISSUE: rd_en=1, rd_addr increments 1..len-1 (cycles 2..len); last address -> DRAIN.
//   DRAIN: rd_en=0; stays MAC_LAT+1 cycles, covering the final mac_en plus MAC_LAT; last
//          cycle registers mac_out into result.
//   DONE : done=1, busy=0, result valid (cycle len+MAC_LAT+2). -> IDLE.
//  mac_en is high in cycles 2..len+1; exactly len pulses per run.
//  rd_addr never exceeds 2**AW-1 and does not wrap within a run.
//  start while not in IDLE (including DONE) is ignored; it is not queued.
//  abort (any state except IDLE) -> IDLE next cycle. rd_en/mac_en/busy are 0 from that
//   cycle on; there is no done; result keeps its prior value. abort has priority over start.
//  Async rst mid-run forces the reset values immediately, including result=0.
//  No arithmetic in this block. Overflow is the mac's concern; result is mac_out verbatim.
// STRUCTURE
//  mac_defs.vh: FSM state localparams (IDLE=0, CLEAR=1, ISSUE=2, DRAIN=3, DONE=4),
//   default ACC_W/AW, and the fixed operand-memory read latency (1).
//  Sub-module mac_issue_ctr: AW+1-bit term counter with load/inc, last-term flag and
//   the rd_addr output. The FSM, mac_en delay and drain counter stay in mac_seq_ctrl.
// TESTING (bench: mac model with MAC_LAT=1; ROM a[i]=i+1, b[i]=2 unless stated)
//  1 len=4, start pulse -> mac_clr at cycle 1; rd_addr 0..3 in cycles 1..4; mac_en
//    in cycles 2..5; done at cycle 7 with result=20; busy high in cycles 1..6.
//  2 len=0 -> done at cycle 1, result=0; rd_en/mac_clr/mac_en never asserted.
//  3 ROM a=b=15, len=16 -> result=3600 at cycle 19. Repeat with len=31 -> clamps to 16,
//    same result and timing, rd_addr max 15.
//  4 len=4; extra start pulses at cycles 3 and 7 -> exactly one done (cycle 7), result=20.
//  5 after test 1, len=4 run with abort at cycle 3 -> busy=0 and rd_en=0 from cycle 4,
//    no done, result stays 20.
//  6 async rst raised mid-cycle at cycle 4 -> outputs 0 before the next edge, result=0;
//    after release, len=2 -> done at cycle 5, result=6.

Source files
------------

// File: rtl/mac_seq_ctrl_pkg.sv
// mac_seq_ctrl_pkg: shared state encoding, default widths and length clamp for the MAC sequencer
package mac_seq_ctrl_pkg;
  localparam int AW_DEF = 4;
  localparam int ACC_W_DEF = 18;
  localparam int RD_LAT = 1;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;
  function automatic int clamp_len(input int l, input int aw);
    return (l > (1 << aw)) ? (1 << aw) : l;
  endfunction
endpackage

// File: rtl/mac_issue_ctr.sv
// mac_issue_ctr: term counter driving the operand-memory address, with last-term flag
module mac_issue_ctr #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW:0]   len,
  input  logic          inc,
  output logic          last,
  output logic [AW-1:0] rd_addr
);
  logic [AW:0] cnt, len_q;
  // latch the clamped term count on start, then step one address per issued read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      len_q <= '0;
    end else if (load) begin
      cnt <= '0;
      len_q <= len;
    end else if (inc) cnt <= cnt + (AW+1)'(1);
  assign last = (cnt + (AW+1)'(1)) == len_q;
  assign rd_addr = cnt[AW-1:0];
endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences clear, operand reads and drain for the MAC, then captures the sum
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int MAC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [AW:0]      len,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  output logic             mac_clr,
  output logic             mac_en,
  input  logic [ACC_W-1:0] mac_out,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result
);
  localparam int DW = $clog2(MAC_LAT + 2);
  state_t state, state_n;
  logic last, load, inc, clr_d, rd_d, busy_d, done_d;
  logic [DW-1:0] dcnt;
  logic [AW:0] len_c;
  assign len_c = (AW+1)'(clamp_len(int'(len), AW));
  assign load = state == IDLE && start;
  assign inc = (state == CLEAR || state == ISSUE) && !last;
  mac_issue_ctr #(.AW(AW)) u_ctr (
    .clk(clk),
    .rst(rst),
    .load(load),
    .len(len_c),
    .inc(inc),
    .last(last),
    .rd_addr(rd_addr)
  );
  // next state; abort overrides everything outside IDLE, so start cannot win over it
  always_comb begin
    state_n = state;
    case (state)
      IDLE:         if (start) state_n = (len_c == '0) ? DONE : CLEAR;
      CLEAR, ISSUE: state_n = last ? DRAIN : ISSUE;
      DRAIN:        if (dcnt == '0) state_n = DONE;
      default:      state_n = IDLE;
    endcase
    if (abort && state != IDLE) state_n = IDLE;
  end
  // outputs are decoded from the next state so they can be registered alongside it
  always_comb begin
    clr_d = state_n == CLEAR;
    rd_d = state_n == CLEAR || state_n == ISSUE;
    busy_d = rd_d || state_n == DRAIN;
    done_d = state_n == DONE;
  end
  // state and control registers; mac_en follows rd_en by the one-cycle memory latency unless aborted
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      mac_clr <= 1'b0;
      rd_en <= 1'b0;
      mac_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      mac_clr <= clr_d;
      rd_en <= rd_d;
      mac_en <= rd_en && state_n != IDLE;
      busy <= busy_d;
      done <= done_d;
    end
  // drain countdown covers the last mac_en plus the MAC latency; result is taken on the way to DONE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dcnt <= '0;
      result <= '0;
    end else begin
      dcnt <= (state != DRAIN) ? DW'(MAC_LAT) : dcnt - DW'(1);
      if (state == IDLE && state_n == DONE) result <= '0;
      else if (state == DRAIN && state_n == DONE) result <= mac_out;
    end
endmodule
